// File: rtl/sticky_accum_if.sv
// Pad-event accumulator bus: capture inputs, clear/read controls and registered status.
// The master drives events and requests; the slave (the accumulator) returns status.
interface sticky_accum_if #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] Din;
    logic             Ce;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] Clr;
    logic             Rd_req;
    logic             Rd_ack;
    logic [WIDTH-1:0] Snap;
    logic [WIDTH-1:0] Dout;
    logic [CNT_W-1:0] Pop;
    logic             Any;
    logic             Full;

    modport master (
        output Din, Ce, Mode, Clr, Rd_req,
        input  Rd_ack, Snap, Dout, Pop, Any, Full
    );

    modport slave (
        input  Din, Ce, Mode, Clr, Rd_req,
        output Rd_ack, Snap, Dout, Pop, Any, Full
    );
endinterface

// File: rtl/sticky_accum.sv
// Sticky per-bit event accumulator with level/edge/toggle capture, mask clear,
// atomic snapshot-and-clear read, and registered population/any/full status.
module sticky_accum #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input logic         CLK,
    input logic         RST,
    sticky_accum_if.slave bus
);

    localparam logic [1:0] MODE_LEVEL  = 2'b00;
    localparam logic [1:0] MODE_RISE   = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;

    logic [WIDTH-1:0] acc_p1;
    logic [WIDTH-1:0] prev_p1;
    logic [WIDTH-1:0] snap_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] pop_p1;
    logic             any_p1;
    logic             full_p1;

    logic [WIDTH-1:0] rise_p0;
    logic [WIDTH-1:0] kept_p0;
    logic [WIDTH-1:0] acc_next_p0;

    function automatic logic [CNT_W-1:0] pop_count(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Stage p0: clear first, then capture, so a same-cycle event survives a clear or read.
    always_comb begin
        rise_p0     = bus.Din & ~prev_p1;
        kept_p0     = acc_p1 & ~bus.Clr & ~(bus.Rd_req ? acc_p1 : '0);
        acc_next_p0 = kept_p0;
        if (bus.Ce) begin
            case (bus.Mode)
                MODE_LEVEL:  acc_next_p0 = kept_p0 | bus.Din;
                MODE_RISE:   acc_next_p0 = kept_p0 | rise_p0;
                MODE_TOGGLE: acc_next_p0 = kept_p0 ^ rise_p0;
                default:     acc_next_p0 = kept_p0;
            endcase
        end
    end

    // Stage p1: accumulator, status and snapshot registered together so they stay coherent.
    always_ff @(posedge CLK) begin
        prev_p1 <= bus.Din;
        if (!RST) begin
            acc_p1  <= '0;
            snap_p1 <= '0;
            vld_p1  <= 1'b0;
            pop_p1  <= '0;
            any_p1  <= 1'b0;
            full_p1 <= 1'b0;
        end else begin
            acc_p1  <= acc_next_p0;
            vld_p1  <= bus.Rd_req;
            pop_p1  <= pop_count(acc_next_p0);
            any_p1  <= |acc_next_p0;
            full_p1 <= &acc_next_p0;
            if (bus.Rd_req) begin
                snap_p1 <= acc_p1;
            end
        end
    end

    assign bus.Dout   = acc_p1;
    assign bus.Snap   = snap_p1;
    assign bus.Rd_ack = vld_p1;
    assign bus.Pop    = pop_p1;
    assign bus.Any    = any_p1;
    assign bus.Full   = full_p1;

endmodule

// File: doc/sticky_accum.md
# sticky_accum

Parametrised sticky-bit event accumulator for the LaunchPad pad-matrix input path. Per-bit flags are set from a WIDTH-bit input under a clock enable. Each flag stays set until it is explicitly cleared. The block adds selectable level/edge/toggle capture modes, a mask clear, an atomic snapshot-and-clear read handshake, and registered population/any/full status. It sits between the debounced pad inputs and the game/sequencer logic that polls pad events.

## Interface
- WIDTH, 12, number of accumulated bits (≥1)
- CNT_W, 4, width of Pop; must satisfy 2^CNT_W > WIDTH
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-low reset
- Din  in  WIDTH  event inputs
- Ce  in  1  capture enable for Din-driven updates
- Mode  in  2  00 level-set, 01 rising-edge-set, 10 rising-edge-toggle, 11 hold
- Clr  in  WIDTH  per-bit clear mask; applied regardless of Ce
- Rd_req  in  1  snapshot-and-clear request, sampled each cycle
- Rd_ack  out  1  one-cycle pulse; Snap valid
- Snap  out  WIDTH  accumulator value captured at the Rd_req cycle
- Dout  out  WIDTH  registered accumulator
- Pop  out  CNT_W  registered count of ones in Dout
- Any  out  1  registered; Dout != 0
- Full  out  1  registered; Dout all ones

## Operation
- Internal prev register holds Din delayed one cycle.
  - prev updates every cycle, independent of Ce and Mode.
  - rise = Din & ~prev.
- Next accumulator value, computed per bit:
  - c = acc & ~Clr & ~(Rd_req ? acc : 0). A read clears exactly the bits it captures.
  - If Ce=0 or Mode=11: acc_next = c.
  - Mode 00: acc_next = c | Din.
  - Mode 01: acc_next = c | rise.
  - Mode 10: acc_next = c ^ rise.
- Clear is applied before update, so an event in the same cycle as a clear or read survives into acc_next.
  - Mode 10: a bit cleared and toggled in the same cycle ends at 1.
- Read handshake:
  - Rd_req=1 in cycle N: Snap <= acc (value before the cycle-N update); Rd_ack <= 1 in cycle N+1.
  - Rd_req held high: every cycle is an independent read; Rd_ack stays high. Each Snap holds only the bits set since the previous read.
  - Rd_req=0: Rd_ack <= 0; Snap holds its last value.
- Pop, Any and Full are computed from acc_next and registered with Dout, so they are always coherent with Dout.
- Edges arriving while Ce=0 are not captured, but prev still tracks Din. An edge is therefore not replayed when Ce rises.
- Mode changes take effect the same cycle. No internal state depends on Mode.

## Timing
- Reset (RST=0 at a rising edge):
  - Dout=0, Snap=0, Rd_ack=0, Pop=0, Any=0, Full=0.
  - prev <= Din, so an input held high through reset creates no spurious edge.
- Reset overrides Rd_req, Ce and Clr in the same cycle. A read requested during reset produces no Rd_ack.
- Latency, Din to Dout: 1 cycle (Mode 00); 1 cycle after the edge cycle (Modes 01/10).
- Latency, Rd_req to Rd_ack/Snap: 1 cycle.
- Latency, Clr to Dout: 1 cycle.
- No combinational path from any input to any output.

## Test plan
- Reset with Din=0xFFF held high, then Mode=01, Ce=1 → Dout stays 0x000; Pop=0.
- Mode=00, Ce=1, Din=0x005 for one cycle then Din=0x000 → Dout=0x005 persists; Pop=2, Any=1, Full=0.
- Mode=10, Ce=1, Din pulses 0x001 three times (0/1/0 pattern) → Dout bit0 sequence 1,0,1. With Ce=0 during a pulse, that edge is lost and Dout is unchanged.
- Dout=0x0F0, Rd_req=1 in the same cycle as Din=0x001 (Mode 00):
  - Next cycle: Snap=0x0F0, Rd_ack=1, Dout=0x001, Pop=1.
  - Following cycle with Rd_req=0: Rd_ack=0.
- Mode=00, Ce=1, Din=0xFFF → Full=1, Pop=12. Then Clr=0x800 with Din=0 → Dout=0x7FF, Full=0, Pop=11.
- Mid-operation reset with Dout=0xABC and Rd_req=1 → next cycle all outputs 0, Rd_ack=0.
